// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
//
// Turns operand-stack ops from decode into single-cycle push/pop commands for
// the external 2048 x 35-bit stack. It tracks the logical depth, rejects ops
// that would underflow or overflow, and holds off ops that read the top of the
// stack until the stack's registered top outputs reflect the last command.
//
// Ports
//   clk, rst_b                 clock, synchronous active-low reset
//   op_valid / op_ready        op handshake; accepted when both high at clk edge
//   op_code                    0 PUSH, 1 POPN, 2 DUP, 3 SWAP, 4 ADD, 5 SUB,
//                              6 PEEK, 7 CLEAR
//   op_imm                     PUSH value
//   op_n                       POPN count
//   res_valid / res_data       PEEK result, one cycle after accept
//   err / err_code             error strobe, one cycle after accept
//                              (1 underflow, 2 overflow)
//   depth                      current logical depth
//   st__push, st__to_pop,
//   st__to_push                registered stack command (one cycle per command)
//   st__top_0, st__top_1       registered top / second-from-top from the stack
// -----------------------------------------------------------------------------
module stack_sequencer #(
  parameter int DEPTH_MAX = 2047,
  parameter int W         = 35,
  parameter int AW        = 11
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [W-1:0]  op_imm,
  input  logic [AW-1:0] op_n,
  output logic          res_valid,
  output logic [W-1:0]  res_data,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [AW:0]   depth,
  output logic          st__push,
  output logic [AW-1:0] st__to_pop,
  output logic [W-1:0]  st__to_push,
  input  logic [W-1:0]  st__top_0,
  input  logic [W-1:0]  st__top_1
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    OP_PUSH  = 3'd0,
    OP_POPN  = 3'd1,
    OP_DUP   = 3'd2,
    OP_SWAP  = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_PEEK  = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWAP2 = 1'b1
  } state_e;

  localparam int          DW        = AW + 1;
  localparam logic [DW-1:0] DEPTH_LIM = DW'(DEPTH_MAX);
  // The stack's top registers lag a command by two cycles.
  localparam logic [1:0]  SETTLE_CYCLES = 2'd2;

  localparam logic [1:0]  ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0]  ERR_OVERFLOW  = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        r_state;
  state_e        w_state_nxt;
  logic [1:0]    r_settle;
  logic [DW-1:0] r_depth;
  logic [W-1:0]  r_swap_t1;      // second-from-top latched at SWAP accept

  logic          r_push;
  logic [AW-1:0] r_to_pop;
  logic [W-1:0]  r_to_push;
  logic          r_err;
  logic [1:0]    r_err_code;
  logic          r_res_valid;
  logic [W-1:0]  r_res_data;

  // ---------------------------------------------------------------------------
  // Op decode (pure function of op_code, operands, depth and stack tops)
  // ---------------------------------------------------------------------------
  logic          w_reads_top;    // op needs settled st__top_* values
  logic          w_grows;        // op adds one entry (overflow candidate)
  logic          w_is_peek;
  logic          w_is_swap;
  logic [DW-1:0] w_need;         // entries the op requires to be present
  logic          w_cmd_push;
  logic [AW-1:0] w_cmd_pop;
  logic [W-1:0]  w_cmd_data;
  logic [DW-1:0] w_depth_nxt;

  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_reads_top = 1'b0;
    w_grows     = 1'b0;
    w_is_peek   = 1'b0;
    w_is_swap   = 1'b0;
    w_need      = '0;
    w_cmd_push  = 1'b0;
    w_cmd_pop   = '0;
    w_cmd_data  = '0;
    w_depth_nxt = r_depth;

    case (op_code)
      OP_PUSH: begin
        w_grows     = 1'b1;
        w_cmd_push  = 1'b1;
        w_cmd_data  = op_imm;
        w_depth_nxt = r_depth + DW'(1);
      end
      OP_POPN: begin
        w_need      = {1'b0, op_n};
        w_cmd_pop   = op_n;
        w_depth_nxt = r_depth - {1'b0, op_n};
      end
      OP_DUP: begin
        w_reads_top = 1'b1;
        w_grows     = 1'b1;
        w_need      = DW'(1);
        w_cmd_push  = 1'b1;
        w_cmd_data  = st__top_0;
        w_depth_nxt = r_depth + DW'(1);
      end
      OP_SWAP: begin
        // First half: drop both, push old top. Second half pushes old second.
        w_reads_top = 1'b1;
        w_is_swap   = 1'b1;
        w_need      = DW'(2);
        w_cmd_push  = 1'b1;
        w_cmd_pop   = AW'(2);
        w_cmd_data  = st__top_0;
      end
      OP_ADD: begin
        w_reads_top = 1'b1;
        w_need      = DW'(2);
        w_cmd_push  = 1'b1;
        w_cmd_pop   = AW'(2);
        w_cmd_data  = st__top_1 + st__top_0;
        w_depth_nxt = r_depth - DW'(1);
      end
      OP_SUB: begin
        w_reads_top = 1'b1;
        w_need      = DW'(2);
        w_cmd_push  = 1'b1;
        w_cmd_pop   = AW'(2);
        w_cmd_data  = st__top_1 - st__top_0;
        w_depth_nxt = r_depth - DW'(1);
      end
      OP_PEEK: begin
        w_reads_top = 1'b1;
        w_is_peek   = 1'b1;
        w_need      = DW'(1);
      end
      OP_CLEAR: begin
        w_cmd_pop   = r_depth[AW-1:0];
        w_depth_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error classification and accept qualification
  // ---------------------------------------------------------------------------
  logic       w_underflow;
  logic       w_overflow;
  logic [1:0] w_err_code;
  logic       w_accept;
  logic       w_reject;
  logic       w_modifies;

  assign w_underflow = (w_need > r_depth);
  // Anything that grows needs at most one entry, so it can never also underflow
  // at the depth limit; underflow still takes priority for clarity.
  assign w_overflow  = w_grows && (r_depth == DEPTH_LIM);
  assign w_err_code  = w_underflow ? ERR_UNDERFLOW :
                       w_overflow  ? ERR_OVERFLOW  : 2'd0;

  assign w_accept    = op_valid && op_ready;
  assign w_reject    = w_underflow || w_overflow;
  // Only ops that actually move the stack disturb the top registers; a POPN of
  // zero or a CLEAR of an empty stack issues an idle command.
  assign w_modifies  = w_cmd_push || (w_cmd_pop != '0);

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state / handshake logic
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    op_ready    = 1'b1;

    case (r_state)
      S_IDLE: begin
        // Top-reading ops wait until the last command has reached the tops.
        if (w_reads_top && (r_settle != 2'd0)) begin
          op_ready = 1'b0;
        end
        if (op_valid && op_ready && w_is_swap && !w_reject) begin
          w_state_nxt = S_SWAP2;
        end
      end
      S_SWAP2: begin
        op_ready    = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: commands, depth, settle counter, result and error strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_settle    <= '0;
      r_depth     <= '0;
      r_swap_t1   <= '0;
      r_push      <= 1'b0;
      r_to_pop    <= '0;
      r_to_push   <= '0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      // Commands and strobes are one-cycle pulses; idle command leaves sp alone.
      r_push      <= 1'b0;
      r_to_pop    <= '0;
      r_to_push   <= '0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_res_valid <= 1'b0;

      if (r_settle != 2'd0) begin
        r_settle <= r_settle - 2'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_reject) begin
              r_err      <= 1'b1;
              r_err_code <= w_err_code;
            end else begin
              r_push    <= w_cmd_push;
              r_to_pop  <= w_cmd_pop;
              r_to_push <= w_cmd_data;
              r_depth   <= w_depth_nxt;
              if (w_modifies) begin
                r_settle <= SETTLE_CYCLES;
              end
              if (w_is_peek) begin
                r_res_valid <= 1'b1;
                r_res_data  <= st__top_0;
              end
              if (w_is_swap) begin
                r_swap_t1 <= st__top_1;
              end
            end
          end
        end
        S_SWAP2: begin
          // Second SWAP command: push the old second entry on top.
          r_push    <= 1'b1;
          r_to_pop  <= '0;
          r_to_push <= r_swap_t1;
          r_settle  <= SETTLE_CYCLES;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign st__push    = r_push;
  assign st__to_pop  = r_to_pop;
  assign st__to_push = r_to_push;
  assign depth       = r_depth;
  assign err         = r_err;
  assign err_code    = r_err_code;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;

endmodule

// File: tb/tb_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_sequencer
//
// Drives stack_sequencer (DEPTH_MAX reduced to 4) against a behavioural stack
// whose top registers lag each command by two cycles. A table of per-cycle
// inputs and expected outputs covers the main flow; a hand-written sequence
// covers reset during the second SWAP cycle.
// -----------------------------------------------------------------------------
module tb_stack_sequencer;

  localparam int W    = 35;
  localparam int AW   = 11;
  localparam int DMAX = 4;

  localparam logic [2:0] C_PUSH  = 3'd0;
  localparam logic [2:0] C_POPN  = 3'd1;
  localparam logic [2:0] C_DUP   = 3'd2;
  localparam logic [2:0] C_SWAP  = 3'd3;
  localparam logic [2:0] C_ADD   = 3'd4;
  localparam logic [2:0] C_SUB   = 3'd5;
  localparam logic [2:0] C_PEEK  = 3'd6;
  localparam logic [2:0] C_CLEAR = 3'd7;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [W-1:0]  op_imm;
  logic [AW-1:0] op_n;
  logic          res_valid;
  logic [W-1:0]  res_data;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   depth;
  logic          st__push;
  logic [AW-1:0] st__to_pop;
  logic [W-1:0]  st__to_push;
  logic [W-1:0]  st__top_0;
  logic [W-1:0]  st__top_1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stack_sequencer #(.DEPTH_MAX(DMAX), .W(W), .AW(AW)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .op_imm      (op_imm),
    .op_n        (op_n),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .err         (err),
    .err_code    (err_code),
    .depth       (depth),
    .st__push    (st__push),
    .st__to_pop  (st__to_pop),
    .st__to_push (st__to_push),
    .st__top_0   (st__top_0),
    .st__top_1   (st__top_1)
  );

  // Behavioural stack: applies pop-then-push at the edge ending a command
  // cycle; tops pass through two register stages.
  logic [W-1:0] mem [0:63];
  int           sp;
  logic [W-1:0] pipe_0, pipe_1;

  always @(posedge clk) begin
    if (!rst_b) begin
      sp = 0;
      pipe_0    <= '0;
      pipe_1    <= '0;
      st__top_0 <= '0;
      st__top_1 <= '0;
    end else begin
      sp = sp - int'(st__to_pop);
      if (sp < 0) sp = 0;
      if (st__push) begin
        mem[sp] = st__to_push;
        sp = sp + 1;
      end
      pipe_0    <= (sp > 0) ? mem[sp-1] : '0;
      pipe_1    <= (sp > 1) ? mem[sp-2] : '0;
      st__top_0 <= pipe_0;
      st__top_1 <= pipe_1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          valid;
    logic [2:0]    code;
    logic [W-1:0]  imm;
    logic [AW-1:0] n;
    logic          rdy;
    logic          push;
    logic [AW-1:0] pop;
    logic [W-1:0]  data;
    logic [AW:0]   dep;
    logic          err;
    logic [1:0]    ec;
    logic          rv;
    logic [W-1:0]  rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic valid, input logic [2:0] code,
                             input logic [W-1:0] imm, input logic [AW-1:0] n,
                             input logic rdy, input logic push,
                             input logic [AW-1:0] pop, input logic [W-1:0] data,
                             input logic [AW:0] dep, input logic e,
                             input logic [1:0] ec, input logic rv,
                             input logic [W-1:0] rd);
    vec_t r;
    r.valid = valid; r.code = code; r.imm = imm; r.n = n;
    r.rdy = rdy; r.push = push; r.pop = pop; r.data = data; r.dep = dep;
    r.err = e; r.ec = ec; r.rv = rv; r.rd = rd;
    return r;
  endfunction

  // Present an op and hold it until accepted (bounded wait).
  task automatic issue(input logic [2:0] code, input logic [W-1:0] imm, input logic [AW-1:0] n);
    int waited = 0;
    op_valid = 1'b1; op_code = code; op_imm = imm; op_n = n;
    @(negedge clk);
    while (!op_ready && waited < 8) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    check("issue_ready_timeout", {63'd0, op_ready}, 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = C_PUSH; op_imm = '0; op_n = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // valid code imm n | rdy push pop data depth err ec rv rd
    tbl.push_back(v(1, C_PUSH,   5, 0, 1, 0, 0,  0, 0, 0, 0, 0,  0)); // R0
    tbl.push_back(v(1, C_PUSH,   7, 0, 1, 1, 0,  5, 1, 0, 0, 0,  0)); // R1 back-to-back
    tbl.push_back(v(1, C_ADD,    0, 0, 0, 1, 0,  7, 2, 0, 0, 0,  0)); // R2 stalled
    tbl.push_back(v(1, C_ADD,    0, 0, 0, 0, 0,  0, 2, 0, 0, 0,  0)); // R3 stalled
    tbl.push_back(v(1, C_ADD,    0, 0, 1, 0, 0,  0, 2, 0, 0, 0,  0)); // R4 accepted
    tbl.push_back(v(1, C_PEEK,   0, 0, 0, 1, 2, 12, 1, 0, 0, 0,  0)); // R5
    tbl.push_back(v(1, C_PEEK,   0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0)); // R6
    tbl.push_back(v(1, C_PEEK,   0, 0, 1, 0, 0,  0, 1, 0, 0, 0,  0)); // R7
    tbl.push_back(v(1, C_PUSH,   3, 0, 1, 0, 0,  0, 1, 0, 0, 1, 12)); // R8 peek=12
    tbl.push_back(v(1, C_PUSH,   9, 0, 1, 1, 0,  3, 2, 0, 0, 0,  0)); // R9
    tbl.push_back(v(1, C_SWAP,   0, 0, 0, 1, 0,  9, 3, 0, 0, 0,  0)); // R10
    tbl.push_back(v(1, C_SWAP,   0, 0, 0, 0, 0,  0, 3, 0, 0, 0,  0)); // R11
    tbl.push_back(v(1, C_SWAP,   0, 0, 1, 0, 0,  0, 3, 0, 0, 0,  0)); // R12 accepted
    tbl.push_back(v(1, C_PUSH,  77, 0, 0, 1, 2,  9, 3, 0, 0, 0,  0)); // R13 SWAP2
    tbl.push_back(v(1, C_PEEK,   0, 0, 0, 1, 0,  3, 3, 0, 0, 0,  0)); // R14
    tbl.push_back(v(1, C_PEEK,   0, 0, 0, 0, 0,  0, 3, 0, 0, 0,  0)); // R15
    tbl.push_back(v(1, C_PEEK,   0, 0, 1, 0, 0,  0, 3, 0, 0, 0,  0)); // R16
    tbl.push_back(v(1, C_POPN,   0, 1, 1, 0, 0,  0, 3, 0, 0, 1,  3)); // R17 peek=3
    tbl.push_back(v(1, C_PEEK,   0, 0, 0, 0, 1,  0, 2, 0, 0, 0,  0)); // R18
    tbl.push_back(v(1, C_PEEK,   0, 0, 0, 0, 0,  0, 2, 0, 0, 0,  0)); // R19
    tbl.push_back(v(1, C_PEEK,   0, 0, 1, 0, 0,  0, 2, 0, 0, 0,  0)); // R20
    tbl.push_back(v(1, C_POPN,   0, 1, 1, 0, 0,  0, 2, 0, 0, 1,  9)); // R21 peek=9
    tbl.push_back(v(1, C_ADD,    0, 0, 0, 0, 1,  0, 1, 0, 0, 0,  0)); // R22
    tbl.push_back(v(1, C_ADD,    0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0)); // R23
    tbl.push_back(v(1, C_ADD,    0, 0, 1, 0, 0,  0, 1, 0, 0, 0,  0)); // R24 underflow
    tbl.push_back(v(1, C_POPN,   0, 0, 1, 0, 0,  0, 1, 1, 1, 0,  0)); // R25 err, POPN 0
    tbl.push_back(v(1, C_POPN,   0, 1, 1, 0, 0,  0, 1, 0, 0, 0,  0)); // R26
    tbl.push_back(v(1, C_PUSH,   0, 0, 1, 0, 1,  0, 0, 0, 0, 0,  0)); // R27
    tbl.push_back(v(1, C_PUSH,   1, 0, 1, 1, 0,  0, 1, 0, 0, 0,  0)); // R28
    tbl.push_back(v(1, C_SUB,    0, 0, 0, 1, 0,  1, 2, 0, 0, 0,  0)); // R29
    tbl.push_back(v(1, C_SUB,    0, 0, 0, 0, 0,  0, 2, 0, 0, 0,  0)); // R30
    tbl.push_back(v(1, C_SUB,    0, 0, 1, 0, 0,  0, 2, 0, 0, 0,  0)); // R31 0-1
    tbl.push_back(v(1, C_PUSH,   2, 0, 1, 1, 2, 35'h7_FFFF_FFFF, 1, 0, 0, 0, 0)); // R32
    tbl.push_back(v(1, C_PUSH,   3, 0, 1, 1, 0,  2, 2, 0, 0, 0,  0)); // R33
    tbl.push_back(v(1, C_PUSH,   4, 0, 1, 1, 0,  3, 3, 0, 0, 0,  0)); // R34
    tbl.push_back(v(1, C_DUP,    0, 0, 0, 1, 0,  4, 4, 0, 0, 0,  0)); // R35
    tbl.push_back(v(1, C_DUP,    0, 0, 0, 0, 0,  0, 4, 0, 0, 0,  0)); // R36
    tbl.push_back(v(1, C_DUP,    0, 0, 1, 0, 0,  0, 4, 0, 0, 0,  0)); // R37 overflow
    tbl.push_back(v(1, C_PUSH,   9, 0, 1, 0, 0,  0, 4, 1, 2, 0,  0)); // R38 overflow
    tbl.push_back(v(1, C_CLEAR,  0, 0, 1, 0, 0,  0, 4, 1, 2, 0,  0)); // R39
    tbl.push_back(v(1, C_PUSH,   5, 0, 1, 0, 4,  0, 0, 0, 0, 0,  0)); // R40 clear cmd
    tbl.push_back(v(0, C_PUSH,   0, 0, 1, 1, 0,  5, 1, 0, 0, 0,  0)); // R41

    // Reset
    rst_b = 1'b0; op_valid = 1'b0; op_code = C_PUSH; op_imm = '0; op_n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     {63'd0, op_ready},   64'd1);
    check("rst_push",      {63'd0, st__push},   64'd0);
    check("rst_to_pop",    64'(st__to_pop),     64'd0);
    check("rst_to_push",   64'(st__to_push),    64'd0);
    check("rst_depth",     64'(depth),          64'd0);
    check("rst_err",       {63'd0, err},        64'd0);
    check("rst_err_code",  64'(err_code),       64'd0);
    check("rst_res_valid", {63'd0, res_valid},  64'd0);
    check("rst_res_data",  64'(res_data),       64'd0);
    rst_b = 1'b1;

    // Table-driven main flow: one row per cycle
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      op_valid = tbl[i].valid; op_code = tbl[i].code;
      op_imm   = tbl[i].imm;   op_n    = tbl[i].n;
      @(negedge clk);
      check($sformatf("r%0d_ready", i), {63'd0, op_ready}, {63'd0, tbl[i].rdy});
      check($sformatf("r%0d_push", i),  {63'd0, st__push}, {63'd0, tbl[i].push});
      check($sformatf("r%0d_to_pop", i), 64'(st__to_pop), 64'(tbl[i].pop));
      if (tbl[i].push)
        check($sformatf("r%0d_to_push", i), 64'(st__to_push), 64'(tbl[i].data));
      check($sformatf("r%0d_depth", i), 64'(depth), 64'(tbl[i].dep));
      check($sformatf("r%0d_err", i), {63'd0, err}, {63'd0, tbl[i].err});
      if (tbl[i].err)
        check($sformatf("r%0d_err_code", i), 64'(err_code), 64'(tbl[i].ec));
      check($sformatf("r%0d_res_valid", i), {63'd0, res_valid}, {63'd0, tbl[i].rv});
      if (tbl[i].rv)
        check($sformatf("r%0d_res_data", i), 64'(res_data), 64'(tbl[i].rd));
    end

    // Reset in the SWAP2 cycle abandons the second command.
    @(posedge clk); #1;
    op_valid = 1'b0;
    issue(C_PUSH, 35'd6, '0);         // stack now 5,6 ; depth 2
    issue(C_SWAP, '0, '0);            // returns just after the accept edge
    rst_b = 1'b0;
    @(negedge clk);
    check("swap2_push",    {63'd0, st__push},  64'd1);
    check("swap2_to_pop",  64'(st__to_pop),    64'd2);
    check("swap2_to_push", 64'(st__to_push),   64'd6);
    check("swap2_ready",   {63'd0, op_ready},  64'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(negedge clk);
    check("swaprst_push",   {63'd0, st__push}, 64'd0);
    check("swaprst_to_pop", 64'(st__to_pop),   64'd0);
    check("swaprst_depth",  64'(depth),        64'd0);
    check("swaprst_ready",  {63'd0, op_ready}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("swaprst_no_second_push", {63'd0, st__push}, 64'd0);
    check("swaprst_depth_hold",     64'(depth),        64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
